pokey_clock_scheduler: RTL and testbench

- Sequences the POKEY base-clock enables: derives the 1.79 MHz tick from the master clock, then chains the 64 kHz and 15 kHz dividers off it.
- Routes the chosen base clock to each of the four audio channels according to AUDCTL.
- Owns divider restart during SKCTL init and on STIMER writes.
- Sits between the register file and the four channel counters.

---
 rtl/pokey_pkg.sv | 26 ++
 rtl/pokey_clock_scheduler_if.sv | 29 ++
 rtl/pokey_clock_scheduler_syncreset_enable_divider.sv | 47 ++++
 rtl/pokey_clock_scheduler.sv | 104 ++++++++++
 tb/tb_pokey_clock_scheduler.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pokey_pkg.sv
// pokey_pkg: shared constants for the POKEY clock scheduling slice.
//   - AUDCTL bit indices used by the channel clock routing
//   - scheduler state encoding
//   - default divider counts
// No ports; imported with "import pokey_pkg::*".
package pokey_pkg;

    // AUDCTL bit indices
    localparam int unsigned AUDCTL_15K     = 0;
    localparam int unsigned AUDCTL_JOIN34  = 3;
    localparam int unsigned AUDCTL_JOIN12  = 4;
    localparam int unsigned AUDCTL_CH3_179 = 5;
    localparam int unsigned AUDCTL_CH1_179 = 6;

    // Scheduler state encoding
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Default divider counts
    localparam int unsigned DEF_CLK_DIV          = 32;
    localparam int unsigned DEF_DIV64_COUNT      = 28;
    localparam int unsigned DEF_DIV15_COUNT      = 114;
    localparam int unsigned DEF_DIV64_RESETCOUNT = 0;
    localparam int unsigned DEF_DIV15_RESETCOUNT = 0;

endpackage

// File: rtl/pokey_clock_scheduler_if.sv
// pokey_clock_scheduler_if: bundle between the register file / channel
// counters and the clock scheduler.
//   master modport (register file side):
//     out ce, skctl_init, stimer_wr, audctl[7:0]
//     in  enable_179, enable_64, enable_15, chan_en[3:0], init_active
//   slave modport (pokey_clock_scheduler): the mirror image.
interface pokey_clock_scheduler_if;

    logic       ce;
    logic       skctl_init;
    logic       stimer_wr;
    logic [7:0] audctl;
    logic       enable_179;
    logic       enable_64;
    logic       enable_15;
    logic [3:0] chan_en;
    logic       init_active;

    modport master (
        output ce, skctl_init, stimer_wr, audctl,
        input  enable_179, enable_64, enable_15, chan_en, init_active
    );

    modport slave (
        input  ce, skctl_init, stimer_wr, audctl,
        output enable_179, enable_64, enable_15, chan_en, init_active
    );

endinterface

// File: rtl/pokey_clock_scheduler_syncreset_enable_divider.sv
// syncreset_enable_divider: counts enable_in pulses and emits a tick on every
// COUNT-th pulse. syncreset reloads the count with RESETCOUNT, so the first
// tick after a restart arrives on pulse COUNT-RESETCOUNT.
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   syncreset  in  synchronous restart (caller qualifies it with ce)
//   enable_in  in  input tick (caller qualifies it with ce)
//   enable_out out tick, only ever high together with enable_in
module syncreset_enable_divider #(
    parameter int unsigned COUNT      = 28,
    parameter int unsigned RESETCOUNT = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic syncreset,
    input  logic enable_in,
    output logic enable_out
);

    localparam int unsigned CW = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [CW-1:0] count;
    // Registered "count is at terminal" flag keeps the output path to a single AND.
    logic          flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            flag  <= 1'b0;
        end else if (syncreset) begin
            // The tick for this cycle (flag & enable_in) still goes out; only the state reloads.
            count <= CW'(RESETCOUNT);
            flag  <= (RESETCOUNT == COUNT - 1);
        end else if (enable_in) begin
            if (flag) begin
                count <= '0;
                flag  <= 1'b0;
            end else begin
                count <= count + 1'b1;
                flag  <= (count == CW'(COUNT - 2));
            end
        end
    end

    assign enable_out = flag & enable_in;

endmodule

// File: rtl/pokey_clock_scheduler.sv
// pokey_clock_scheduler: derives the 1.79 MHz tick from the master clock
// enable, chains the 64 kHz and 15 kHz dividers off it, and routes the
// selected base clock to the four audio channels according to AUDCTL.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of pokey_clock_scheduler_if:
//            ce, skctl_init, stimer_wr, audctl in;
//            enable_179, enable_64, enable_15, chan_en[3:0], init_active out
// Build option: define POKEY_STIMER_RESYNC_EN to let STIMER writes restart
// both dividers; otherwise they restart only while in INIT.
module pokey_clock_scheduler
    import pokey_pkg::*;
#(
    parameter int unsigned CLK_DIV          = DEF_CLK_DIV,
    parameter int unsigned DIV64_COUNT      = DEF_DIV64_COUNT,
    parameter int unsigned DIV15_COUNT      = DEF_DIV15_COUNT,
    parameter int unsigned DIV64_RESETCOUNT = DEF_DIV64_RESETCOUNT,
    parameter int unsigned DIV15_RESETCOUNT = DEF_DIV15_RESETCOUNT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pokey_clock_scheduler_if.slave  bus
);

    localparam int unsigned PW = $clog2(CLK_DIV);

    logic [PW-1:0] presc;
    logic [0:0]    state;
    logic [0:0]    state_next;
    logic          init_q;
    logic          restart;
    logic          tick_179;
    logic          tick_64;
    logic          tick_15;
    logic          base;
    logic          unused_join;

    // skctl_init alone decides the next state: high forces INIT (even over
    // stimer_wr), low leaves or stays out of INIT.
    always_comb begin
        state_next = bus.skctl_init ? ST_INIT : ST_RUN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_INIT;
            presc  <= '0;
            init_q <= 1'b0;
        end else if (bus.ce) begin
            state  <= state_next;
            init_q <= (state_next == ST_INIT);
            if (state == ST_INIT || presc == PW'(CLK_DIV - 1)) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign tick_179 = bus.ce && (state == ST_RUN) && (presc == PW'(CLK_DIV - 1));

`ifdef POKEY_STIMER_RESYNC_EN
    assign restart = bus.ce && ((state == ST_INIT) || bus.stimer_wr);
`else
    assign restart = bus.ce && (state == ST_INIT);
`endif

    syncreset_enable_divider #(
        .COUNT      (DIV64_COUNT),
        .RESETCOUNT (DIV64_RESETCOUNT)
    ) u_div64 (
        .clk        (clk),
        .reset_n    (reset_n),
        .syncreset  (restart),
        .enable_in  (tick_179),
        .enable_out (tick_64)
    );

    syncreset_enable_divider #(
        .COUNT      (DIV15_COUNT),
        .RESETCOUNT (DIV15_RESETCOUNT)
    ) u_div15 (
        .clk        (clk),
        .reset_n    (reset_n),
        .syncreset  (restart),
        .enable_in  (tick_179),
        .enable_out (tick_15)
    );

    // Join bits are handled by the channel counters, not by routing.
    assign unused_join = bus.audctl[AUDCTL_JOIN12] ^ bus.audctl[AUDCTL_JOIN34];

    assign base = bus.audctl[AUDCTL_15K] ? tick_15 : tick_64;

    assign bus.enable_179  = tick_179;
    assign bus.enable_64   = tick_64;
    assign bus.enable_15   = tick_15;
    assign bus.chan_en[0]  = bus.audctl[AUDCTL_CH1_179] ? tick_179 : base;
    assign bus.chan_en[1]  = base;
    assign bus.chan_en[2]  = bus.audctl[AUDCTL_CH3_179] ? tick_179 : base;
    assign bus.chan_en[3]  = base;
    assign bus.init_active = init_q;

endmodule

// File: tb/tb_pokey_clock_scheduler.sv
// Scoreboard bench for pokey_clock_scheduler: each stimulus cycle pushes the
// expected output word into a queue; a monitor on the falling edge pops and
// compares. The reference model tracks ce cycles since leaving INIT and
// 1.79 MHz pulses since the last divider restart, and derives ticks by
// modular arithmetic.
module tb_pokey_clock_scheduler;

    localparam int unsigned CLK_DIV = 32;
    localparam int unsigned D64     = 28;
    localparam int unsigned D15     = 114;
    localparam int unsigned R64     = 0;
    localparam int unsigned R15     = 0;

    typedef struct packed {
        logic       e179;
        logic       e64;
        logic       e15;
        logic [3:0] chan;
        logic       init;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pokey_clock_scheduler_if bus ();

    pokey_clock_scheduler #(
        .CLK_DIV          (CLK_DIV),
        .DIV64_COUNT      (D64),
        .DIV15_COUNT      (D15),
        .DIV64_RESETCOUNT (R64),
        .DIV15_RESETCOUNT (R15)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;

    // Reference model state
    bit m_init;      // currently in init mode
    bit m_flag;      // init_active as the DUT should show it
    int m_phase;     // ce cycles since leaving init, modulo CLK_DIV
    int n64, n15;    // 1.79 MHz pulses since restart, offset by resetcount

    task automatic step(input bit rst, input bit ce, input bit ski,
                        input bit stw, input logic [7:0] aud);
        exp_t e;
        bit   e179, e64, e15, base, restart;
        @(posedge clk);
        #1;
        cyc++;
        bus.ce         = ce;
        bus.skctl_init = ski;
        bus.stimer_wr  = stw;
        bus.audctl     = aud;
        if (!rst) begin
            reset_n = 1'b0;
            m_init  = 1'b1;
            m_flag  = 1'b0;
            m_phase = 0;
            n64     = 0;
            n15     = 0;
            e       = '0;
            q.push_back(e);
        end else begin
            reset_n = 1'b1;
            e179 = ce && !m_init && (m_phase == CLK_DIV - 1);
            e64  = e179 && ((n64 + 1) % D64 == 0);
            e15  = e179 && ((n15 + 1) % D15 == 0);
            base = aud[0] ? e15 : e64;
            e.e179 = e179;
            e.e64  = e64;
            e.e15  = e15;
            e.chan = {base, aud[5] ? e179 : base, base, aud[6] ? e179 : base};
            e.init = m_flag;
            q.push_back(e);
            if (ce) begin
                restart = m_init;
`ifdef POKEY_STIMER_RESYNC_EN
                restart = restart || stw;
`endif
                if (e179) begin
                    n64++;
                    n15++;
                end
                if (restart) begin
                    n64 = R64;
                    n15 = R15;
                end
                m_phase = m_init ? 0 : (m_phase + 1) % CLK_DIV;
                m_init  = ski;
                m_flag  = ski;
            end
        end
    endtask

    // Monitor: compare every presented output word against the queue head.
    initial begin
        exp_t e, g;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                g.e179 = bus.enable_179;
                g.e64  = bus.enable_64;
                g.e15  = bus.enable_15;
                g.chan = bus.chan_en;
                g.init = bus.init_active;
                total_cnt++;
                if (g === e) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL outputs cycle %0d: got e179/e64/e15/chan/init=%b/%b/%b/%b/%b required %b/%b/%b/%b/%b",
                             cyc, g.e179, g.e64, g.e15, g.chan, g.init,
                             e.e179, e.e64, e.e15, e.chan, e.init);
                end
            end
        end
    end

    initial begin
        logic [7:0] aud_r;
        bit         ce_r, ski_r, stw_r;
        bus.ce         = 1'b1;
        bus.skctl_init = 1'b1;
        bus.stimer_wr  = 1'b0;
        bus.audctl     = 8'h00;

        // Reset, then held in init mode
        for (int i = 0; i < 5; i++)   step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 500; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);

        // Run, 64 kHz base on all channels
        for (int i = 0; i < 2000; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // 15 kHz base, channels 1 and 3 on 1.79 MHz
        for (int i = 0; i < 8000; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h61);

        // ce toggling: every period doubles
        for (int i = 0; i < 2000; i++) step(1'b1, (i % 2) == 0, 1'b0, 1'b0, 8'h00);

        // STIMER after 10 pulses from a fresh restart
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 320; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 28 * 32 + 64; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // One-cycle init pulse together with a STIMER write
        for (int i = 0; i < 45; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h20);
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h20);

        // Mid-run asynchronous reset
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b1, 1'b0, 1'b0, 8'h40);
        for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h40);

        // Randomised traffic
        aud_r = 8'h00;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 499) == 0) aud_r = 8'($urandom);
            ce_r  = ($urandom_range(0, 3) != 0);
            ski_r = ($urandom_range(0, 1999) == 0);
            stw_r = ($urandom_range(0, 199) == 0);
            step(1'b1, ce_r, ski_r, stw_r, aud_r);
        end

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total_cnt++;
            $display("FAIL queue_drain: %0d entries left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
